sram_arb_ctrl: RTL and testbench
================================

SRAM_ARB_CTRL -- requirements
Module: sram_arb_ctrl

Interface
REQ-001 Parameter DEPTH, default 8192: number of implemented 32-bit words; legal addresses 0..DEPTH-1.
REQ-002 Parameter INIT_EN, default 1: 1 = zero-fill the SRAM after reset, 0 = start directly in RUN.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-high.
REQ-005 Ports p0_req, p1_req  input  1: requester N access request; held high until granted.
REQ-006 Ports p0_we, p1_we  input  4: byte-lane write enables; 4'h0 = read.
REQ-007 Ports p0_addr, p1_addr  input  13: word address.
REQ-008 Ports p0_wdata, p1_wdata  input  32: write data.
REQ-009 Ports p0_gnt, p1_gnt  output  1: request accepted this cycle (combinational).
REQ-010 Ports p0_rvalid, p1_rvalid  output  1: response valid, one cycle after grant.
REQ-011 Ports p0_rdata, p1_rdata  output  32: read data, qualified by rvalid.
REQ-012 Ports p0_err, p1_err  output  1: out-of-range access flag, same timing as rvalid.
REQ-013 Ports sram_cen  output  1; sram_wen  output  4; sram_a  output  13; sram_d  output  32: SRAM macro controls.
REQ-014 Port sram_q  input  32: SRAM registered read data, valid the cycle after a read access.
REQ-015 Port init_done  output  1: high once the SRAM is usable.

Function
REQ-016 FSM states SHALL be INIT and RUN; after reset the FSM SHALL enter INIT if INIT_EN=1, else RUN.
REQ-017 In INIT, each cycle SHALL drive sram_cen=1, sram_wen=4'hF, sram_a=cnt, sram_d=0; cnt SHALL count 0..DEPTH-1.
REQ-018 When cnt=DEPTH-1, the FSM SHALL go to RUN on the next edge; init_done SHALL be registered high from the first RUN cycle onward.
REQ-019 In INIT, p0_gnt and p1_gnt SHALL be 0 regardless of requests.
REQ-020 In RUN, a single active req SHALL be granted in the same cycle.
REQ-021 In RUN, with both reqs active, the port not granted most recently SHALL win (round-robin); the last-grant pointer SHALL update only on a grant.
REQ-022 At most one grant SHALL occur per cycle; sustained throughput SHALL be one access per cycle.
REQ-023 Granted, in-range access: sram_cen=1, sram_a=addr, sram_d=wdata, sram_wen=we, all in the grant cycle.
REQ-024 Any granted access SHALL assert pN_rvalid for exactly one cycle in the cycle after the grant.
REQ-025 pN_rdata SHALL equal sram_q when pN_rvalid=1 for an in-range read, and 0 otherwise.
REQ-026 Granted access with addr >= DEPTH: no SRAM access (sram_cen=0); next cycle pN_rvalid=1, pN_err=1, pN_rdata=0.
REQ-027 With no grant and not in INIT: sram_cen=0, sram_wen=0, sram_a=0, sram_d=0.
REQ-028 A response and a new grant in the same cycle SHALL both proceed; responses SHALL go to the port that owned the access.
REQ-029 A read issued in the cycle after a write to the same address SHALL return the newly written byte lanes.

Reset
REQ-030 While rst=1, the block SHALL set: all gnt/rvalid/err=0; rdata=0; sram_cen=0; cnt=0; init_done=0; last-grant pointer = p1, so p0 wins the first contest.
REQ-031 Reset during INIT SHALL restart the fill from address 0.
REQ-032 Reset during RUN SHALL discard any pending response; no rvalid SHALL appear after reset.

Structure
REQ-033 Package sram_ctrl_pkg SHALL hold the address width (13), data width (32), lane count (4) and the FSM state enumeration.
REQ-034 Round-robin selection SHALL live in sub-module sram_rr_arb2: two req in, two one-hot gnt out, internal last-grant pointer.

Verification
REQ-035 INIT_EN=1, DEPTH=16: release reset -> 16 zero-fill cycles at addresses 0..15, init_done rises in cycle 17, and no gnt during INIT.
REQ-036 p0 writes 0x12345678 to addr 5 with we=4'hF, then we=4'h2 with data 0x0000AB00, then reads -> rdata 0x1234AB78 one cycle after the read grant.
REQ-037 p0 and p1 both hold req for 4 cycles -> grants p0, p1, p0, p1, and each rvalid goes to the correct port.
REQ-038 p1 reads addr 0x1FFF with DEPTH=4096 -> sram_cen=0, next cycle p1_rvalid=1, p1_err=1, p1_rdata=0.
REQ-039 Assert rst for one cycle between a read grant and its response -> no rvalid, state RUN/INIT re-entered per INIT_EN, and cnt restarts at 0.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared widths and FSM state type for the SRAM arbiter/controller
package sram_ctrl_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int LANES  = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sram_arb_ctrl_if.sv
// rtl/sram_arb_ctrl_if.sv - one requester port: request/grant plus one-cycle-later response
interface sram_arb_ctrl_if;
    import sram_ctrl_pkg::*;

    logic              req;
    logic [LANES-1:0]  we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, err
    );

endinterface

// File: rtl/sram_rr_arb2.sv
// rtl/sram_rr_arb2.sv - two-way round-robin arbiter, one-hot grant, pointer moves only on a grant
module sram_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // last_q = 1 means requester 1 was granted most recently
    logic last_q;
    logic last_d;

    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        if (en) begin
            if (req[0] && (!req[1] || last_q)) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end
        if (gnt[0]) begin
            last_d = 1'b0;
        end else if (gnt[1]) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sram_arb_ctrl.sv
// rtl/sram_arb_ctrl.sv - two-port arbitrated SRAM controller with optional zero-fill after reset
module sram_arb_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DEPTH   = 8192,
    parameter bit INIT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    sram_arb_ctrl_if.slave    p0,
    sram_arb_ctrl_if.slave    p1,
    output logic              sram_cen,
    output logic [LANES-1:0]  sram_wen,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q,
    output logic              init_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [31:0]       DEPTH_U   = 32'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              init_done_q, init_done_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_port_q, rsp_port_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_rd_q, rsp_rd_d;

    logic [1:0]        gnt;
    logic              arb_en;
    logic              granted;
    logic              sel;
    logic [LANES-1:0]  g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic              in_range;

    assign arb_en = (state_q == ST_RUN) && !rst;

    sram_rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (arb_en),
        .req ({p1.req, p0.req}),
        .gnt (gnt)
    );

    assign granted  = |gnt;
    assign sel      = gnt[1];
    assign g_we     = sel ? p1.we    : p0.we;
    assign g_addr   = sel ? p1.addr  : p0.addr;
    assign g_wdata  = sel ? p1.wdata : p0.wdata;
    assign in_range = 32'(g_addr) < DEPTH_U;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        rsp_valid_d = 1'b0;
        rsp_port_d  = rsp_port_q;
        rsp_err_d   = 1'b0;
        rsp_rd_d    = 1'b0;
        sram_cen    = 1'b0;
        sram_wen    = '0;
        sram_a      = '0;
        sram_d      = '0;

        case (state_q)
            ST_INIT: begin
                sram_cen = 1'b1;
                sram_wen = '1;
                sram_a   = cnt_q;
                if (cnt_q == LAST_ADDR) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                init_done_d = 1'b1;
                rsp_valid_d = granted;
                rsp_port_d  = sel;
                rsp_err_d   = granted && !in_range;
                rsp_rd_d    = granted && in_range && (g_we == '0);
                if (granted && in_range) begin
                    sram_cen = 1'b1;
                    sram_wen = g_we;
                    sram_a   = g_addr;
                    sram_d   = g_wdata;
                end
            end
        endcase

        // Outputs stay quiet for the whole reset cycle, not only after it is sampled
        if (rst) begin
            sram_cen = 1'b0;
            sram_wen = '0;
            sram_a   = '0;
            sram_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT_EN ? ST_INIT : ST_RUN;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rd_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_port_q  <= rsp_port_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rd_q    <= rsp_rd_d;
        end
    end

    logic rv0, rv1;
    assign rv0 = rsp_valid_q && !rst && !rsp_port_q;
    assign rv1 = rsp_valid_q && !rst &&  rsp_port_q;

    assign p0.gnt    = gnt[0];
    assign p1.gnt    = gnt[1];
    assign p0.rvalid = rv0;
    assign p1.rvalid = rv1;
    assign p0.err    = rv0 && rsp_err_q;
    assign p1.err    = rv1 && rsp_err_q;
    assign p0.rdata  = (rv0 && rsp_rd_q) ? sram_q : '0;
    assign p1.rdata  = (rv1 && rsp_rd_q) ? sram_q : '0;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// tb/tb_sram_arb_ctrl.sv - directed bench: A = DEPTH 16 with zero-fill, B = DEPTH 4096 without
module tb_sram_arb_ctrl;
    import sram_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_arb_ctrl_if a_p0 ();
    sram_arb_ctrl_if a_p1 ();
    sram_arb_ctrl_if b_p0 ();
    sram_arb_ctrl_if b_p1 ();

    logic        a_cen, b_cen;
    logic [3:0]  a_wen, b_wen;
    logic [12:0] a_a, b_a;
    logic [31:0] a_d, b_d, a_q, b_q;
    logic        a_done, b_done;
    logic [31:0] a_mem [0:8191];
    logic [31:0] b_mem [0:8191];

    int n_chk  = 0;
    int n_fail = 0;

    sram_arb_ctrl #(.DEPTH(16), .INIT_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .p0(a_p0), .p1(a_p1),
        .sram_cen(a_cen), .sram_wen(a_wen), .sram_a(a_a), .sram_d(a_d),
        .sram_q(a_q), .init_done(a_done)
    );

    sram_arb_ctrl #(.DEPTH(4096), .INIT_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .p0(b_p0), .p1(b_p1),
        .sram_cen(b_cen), .sram_wen(b_wen), .sram_a(b_a), .sram_d(b_d),
        .sram_q(b_q), .init_done(b_done)
    );

    always @(posedge clk) begin
        logic [31:0] w;
        if (a_cen) begin
            w = a_mem[a_a];
            for (int l = 0; l < 4; l++) if (a_wen[l]) w[8*l +: 8] = a_d[8*l +: 8];
            a_mem[a_a] <= w;
            if (a_wen == 4'h0) a_q <= a_mem[a_a];
        end
        if (b_cen) begin
            w = b_mem[b_a];
            for (int l = 0; l < 4; l++) if (b_wen[l]) w[8*l +: 8] = b_d[8*l +: 8];
            b_mem[b_a] <= w;
            if (b_wen == 4'h0) b_q <= b_mem[b_a];
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle;
        a_p0.req = 0; a_p0.we = 0; a_p0.addr = 0; a_p0.wdata = 0;
        a_p1.req = 0; a_p1.we = 0; a_p1.addr = 0; a_p1.wdata = 0;
        b_p0.req = 0; b_p0.we = 0; b_p0.addr = 0; b_p0.wdata = 0;
        b_p1.req = 0; b_p1.we = 0; b_p1.addr = 0; b_p1.wdata = 0;
    endtask

    task automatic test_reset;
        logic [7:0] obs;
        drive_idle();
        rst = 1;
        a_p0.req = 1; a_p1.req = 1; b_p0.req = 1;
        cyc(); cyc();
        #1;
        obs = {a_p0.gnt, a_p1.gnt, a_p0.rvalid, a_p1.rvalid, a_p0.err, a_cen, a_done, b_p0.gnt};
        n_chk++;
        if (obs !== 8'h00) begin
            n_fail++; $display("FAIL reset_ctrl_a: got %h expected %h", obs, 8'h00);
        end
        n_chk++;
        if ({a_p0.rdata, a_p1.rdata, b_cen, b_done, b_p0.rvalid} !== 35'h0) begin
            n_fail++; $display("FAIL reset_data: got %h expected %h",
                {a_p0.rdata, a_p1.rdata, b_cen, b_done, b_p0.rvalid}, 35'h0);
        end
    endtask

    task automatic test_init;
        logic [52:0] obs, exp;
        b_p0.req = 0;
        rst = 0;
        #1;
        for (int i = 0; i < 16; i++) begin
            obs = {a_cen, a_wen, a_a, a_d, a_p0.gnt, a_p1.gnt, a_done};
            exp = {1'b1, 4'hF, 13'(i), 32'h0, 2'b00, 1'b0};
            n_chk++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL init_fill[%0d]: got %h expected %h", i, obs, exp);
            end
            cyc();
        end
        a_p0.req = 0; a_p1.req = 0;
        #1;
        n_chk++;
        if ({a_done, a_cen, b_done} !== 3'b101) begin
            n_fail++; $display("FAIL init_done: got %b expected %b", {a_done, a_cen, b_done}, 3'b101);
        end
        cyc();
    endtask

    task automatic test_round_robin;
        logic [3:0]  p0we [4] = '{4'hF, 4'h0, 4'h0, 4'h0};
        logic [12:0] p0ad [4] = '{13'd1, 13'd2, 13'd2, 13'd2};
        logic [3:0]  p1we [4] = '{4'hF, 4'hF, 4'h0, 4'h0};
        logic [12:0] p1ad [4] = '{13'd2, 13'd2, 13'd1, 13'd1};
        logic [12:0] expa [4] = '{13'd1, 13'd2, 13'd2, 13'd1};
        logic [80:0] obs, exp;
        logic [1:0]  eg, erv;
        a_p0.wdata = 32'hA0A0A0A0;
        a_p1.wdata = 32'hB1B1B1B1;
        for (int k = 0; k < 4; k++) begin
            a_p0.req = 1; a_p0.we = p0we[k]; a_p0.addr = p0ad[k];
            a_p1.req = 1; a_p1.we = p1we[k]; a_p1.addr = p1ad[k];
            #1;
            eg  = (k % 2 == 0) ? 2'b10 : 2'b01;
            erv = (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b10 : 2'b01);
            exp = {eg, expa[k], erv, (k == 3) ? 32'hB1B1B1B1 : 32'h0, 32'h0};
            obs = {a_p0.gnt, a_p1.gnt, a_a, a_p0.rvalid, a_p1.rvalid, a_p0.rdata, a_p1.rdata};
            n_chk++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL rr_cycle[%0d]: got %h expected %h", k, obs, exp);
            end
            cyc();
        end
        a_p0.req = 0; a_p1.req = 0;
        #1;
        n_chk++;
        if ({a_p0.rvalid, a_p1.rvalid, a_p0.rdata, a_p1.rdata} !== {2'b01, 32'h0, 32'hA0A0A0A0}) begin
            n_fail++; $display("FAIL rr_last_rsp: got %h expected %h",
                {a_p0.rvalid, a_p1.rvalid, a_p0.rdata, a_p1.rdata}, {2'b01, 32'h0, 32'hA0A0A0A0});
        end
        cyc();
    endtask

    task automatic test_write_merge;
        a_p0.req = 1; a_p0.we = 4'hF; a_p0.addr = 13'd5; a_p0.wdata = 32'h12345678;
        #1;
        n_chk++;
        if ({a_p0.gnt, a_cen, a_wen, a_a, a_d} !== {2'b11, 4'hF, 13'd5, 32'h12345678}) begin
            n_fail++; $display("FAIL wm_write_full: got %h expected %h",
                {a_p0.gnt, a_cen, a_wen, a_a, a_d}, {2'b11, 4'hF, 13'd5, 32'h12345678});
        end
        cyc();
        a_p0.we = 4'h2; a_p0.wdata = 32'h0000AB00;
        #1;
        n_chk++;
        if ({a_p0.gnt, a_wen, a_d, a_p0.rvalid, a_p0.err, a_p0.rdata} !== {1'b1, 4'h2, 32'h0000AB00, 2'b10, 32'h0}) begin
            n_fail++; $display("FAIL wm_write_lane: got %h expected %h",
                {a_p0.gnt, a_wen, a_d, a_p0.rvalid, a_p0.err, a_p0.rdata}, {1'b1, 4'h2, 32'h0000AB00, 2'b10, 32'h0});
        end
        cyc();
        a_p0.we = 4'h0;
        #1;
        n_chk++;
        if ({a_p0.gnt, a_cen, a_wen, a_a, a_p0.rvalid} !== {2'b11, 4'h0, 13'd5, 1'b1}) begin
            n_fail++; $display("FAIL wm_read_issue: got %h expected %h",
                {a_p0.gnt, a_cen, a_wen, a_a, a_p0.rvalid}, {2'b11, 4'h0, 13'd5, 1'b1});
        end
        cyc();
        a_p0.req = 0;
        #1;
        n_chk++;
        if ({a_p0.rvalid, a_p0.err, a_p0.rdata, a_p1.rvalid} !== {2'b10, 32'h1234AB78, 1'b0}) begin
            n_fail++; $display("FAIL wm_read_data: got %h expected %h",
                {a_p0.rvalid, a_p0.err, a_p0.rdata, a_p1.rvalid}, {2'b10, 32'h1234AB78, 1'b0});
        end
        cyc();
        #1;
        n_chk++;
        if ({a_p0.rvalid, a_cen, a_wen, a_a, a_d, a_p0.gnt, a_p1.gnt} !== 53'h0) begin
            n_fail++; $display("FAIL wm_idle: got %h expected %h",
                {a_p0.rvalid, a_cen, a_wen, a_a, a_d, a_p0.gnt, a_p1.gnt}, 53'h0);
        end
    endtask

    task automatic test_out_of_range;
        a_p1.req = 1; a_p1.we = 4'h0; a_p1.addr = 13'h1FFF;
        #1;
        n_chk++;
        if ({a_p1.gnt, a_cen} !== 2'b10) begin
            n_fail++; $display("FAIL oor_a_issue: got %b expected %b", {a_p1.gnt, a_cen}, 2'b10);
        end
        cyc();
        a_p1.req = 0;
        #1;
        n_chk++;
        if ({a_p1.rvalid, a_p1.err, a_p1.rdata, a_p0.rvalid} !== {2'b11, 32'h0, 1'b0}) begin
            n_fail++; $display("FAIL oor_a_rsp: got %h expected %h",
                {a_p1.rvalid, a_p1.err, a_p1.rdata, a_p0.rvalid}, {2'b11, 32'h0, 1'b0});
        end
        cyc();
        b_p1.req = 1; b_p1.we = 4'hF; b_p1.addr = 13'hFFF; b_p1.wdata = 32'hCAFEF00D;
        #1;
        n_chk++;
        if ({b_p1.gnt, b_cen, b_a} !== {2'b11, 13'hFFF}) begin
            n_fail++; $display("FAIL oor_b_edge_write: got %h expected %h", {b_p1.gnt, b_cen, b_a}, {2'b11, 13'hFFF});
        end
        cyc();
        b_p1.we = 4'h0; b_p1.addr = 13'h1FFF;
        #1;
        n_chk++;
        if ({b_p1.gnt, b_cen, b_p1.rvalid, b_p1.err} !== 4'b1010) begin
            n_fail++; $display("FAIL oor_b_issue: got %b expected %b", {b_p1.gnt, b_cen, b_p1.rvalid, b_p1.err}, 4'b1010);
        end
        cyc();
        b_p1.addr = 13'hFFF;
        #1;
        n_chk++;
        if ({b_p1.gnt, b_cen, b_p1.rvalid, b_p1.err, b_p1.rdata} !== {4'b1111, 32'h0}) begin
            n_fail++; $display("FAIL oor_b_rsp: got %h expected %h",
                {b_p1.gnt, b_cen, b_p1.rvalid, b_p1.err, b_p1.rdata}, {4'b1111, 32'h0});
        end
        cyc();
        b_p1.req = 0;
        #1;
        n_chk++;
        if ({b_p1.rvalid, b_p1.err, b_p1.rdata} !== {2'b10, 32'hCAFEF00D}) begin
            n_fail++; $display("FAIL oor_b_edge_read: got %h expected %h",
                {b_p1.rvalid, b_p1.err, b_p1.rdata}, {2'b10, 32'hCAFEF00D});
        end
        cyc();
    endtask

    task automatic test_reset_midflight;
        a_p0.req = 1; a_p0.we = 4'h0; a_p0.addr = 13'd5;
        b_p1.req = 1; b_p1.we = 4'h0; b_p1.addr = 13'hFFF;
        #1;
        n_chk++;
        if ({a_p0.gnt, b_p1.gnt} !== 2'b11) begin
            n_fail++; $display("FAIL mid_grant: got %b expected %b", {a_p0.gnt, b_p1.gnt}, 2'b11);
        end
        cyc();
        rst = 1;
        a_p0.req = 0; b_p1.req = 0;
        #1;
        n_chk++;
        if ({a_p0.rvalid, b_p1.rvalid, a_cen, b_cen} !== 4'b0000) begin
            n_fail++; $display("FAIL mid_in_reset: got %b expected %b", {a_p0.rvalid, b_p1.rvalid, a_cen, b_cen}, 4'b0000);
        end
        cyc();
        rst = 0;
        b_p0.req = 1; b_p0.we = 4'hF; b_p0.addr = 13'd7; b_p0.wdata = 32'h1;
        #1;
        n_chk++;
        if ({a_p0.rvalid, a_done, a_cen, a_a, b_p1.rvalid, b_p0.gnt, b_cen} !== {3'b001, 13'd0, 3'b011}) begin
            n_fail++; $display("FAIL mid_restart: got %h expected %h",
                {a_p0.rvalid, a_done, a_cen, a_a, b_p1.rvalid, b_p0.gnt, b_cen}, {3'b001, 13'd0, 3'b011});
        end
        cyc();
        b_p0.req = 0;
        #1;
        n_chk++;
        if ({a_a, a_cen, a_p0.rvalid, b_p0.rvalid, b_p1.rvalid} !== {13'd1, 4'b1010}) begin
            n_fail++; $display("FAIL mid_after: got %h expected %h",
                {a_a, a_cen, a_p0.rvalid, b_p0.rvalid, b_p1.rvalid}, {13'd1, 4'b1010});
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_init();
        test_round_robin();
        test_write_merge();
        test_out_of_range();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
